// File: rtl/number_gen_if.sv
// Pixel bus between a raster source and a glyph renderer.
// Master drives the raster position and digit; slave returns the coverage and colour.
// No flow control: one pixel per clock, results follow one clock later.
interface number_gen_if;
    logic       visible;
    logic [9:0] col;
    logic [9:0] row;
    logic [3:0] digit;
    logic       number_on;
    logic [5:0] number_rgb;

    modport master (
        output visible, col, row, digit,
        input  number_on, number_rgb
    );

    modport slave (
        input  visible, col, row, digit,
        output number_on, number_rgb
    );
endinterface

// File: rtl/number_gen.sv
// Seven-segment digit renderer inside a fixed WxH box on the VGA raster.
// Latency: 1 clk from col/row/visible/digit to number_on/number_rgb.
// Backpressure: none, one pixel accepted every clock. NUMBER_GEN_BOX_EN adds a BOX_RGB border.
module number_gen #(
    parameter int          X0     = 100,
    parameter int          Y0     = 100,
    parameter int          W      = 20,
    parameter int          H      = 30,
    parameter int          SEG_T  = 4,
    parameter logic [5:0]  FG_RGB = 6'b111111,
    parameter logic [5:0]  BG_RGB = 6'b000000
`ifdef NUMBER_GEN_BOX_EN
    ,
    parameter logic [5:0]  BOX_RGB = 6'b010101
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    number_gen_if.slave  pix
);

    // Geometry widened to 11 bits so box limits near 1023 never wrap.
    localparam logic [10:0] X_LO    = 11'(X0);
    localparam logic [10:0] X_HI    = 11'(X0 + W);
    localparam logic [10:0] Y_LO    = 11'(Y0);
    localparam logic [10:0] Y_HI    = 11'(Y0 + H);
    localparam logic [10:0] T_L     = 11'(SEG_T);
    localparam logic [10:0] MID_L   = 11'(H / 2);
    localparam logic [10:0] G_LO    = 11'(H / 2 - SEG_T / 2);
    localparam logic [10:0] G_HI    = 11'(H / 2 + SEG_T / 2);
    localparam logic [10:0] D_LO    = 11'(H - SEG_T);
    localparam logic [10:0] R_LO    = 11'(W - SEG_T);
`ifdef NUMBER_GEN_BOX_EN
    localparam logic [10:0] X_LAST  = 11'(W - 1);
    localparam logic [10:0] Y_LAST  = 11'(H - 1);
`endif

    logic [10:0] col_w, row_w, sx, sy;
    logic        inbox, fg;
    logic [6:0]  seg_hit;   // {g,f,e,d,c,b,a} regions covering this pixel
    logic [6:0]  seg_lit;   // {g,f,e,d,c,b,a} segments lit for the digit
    logic        number_on_d, number_on_q;
    logic [5:0]  number_rgb_d, number_rgb_q;

    // Region hit test and digit decode; sx/sy are only meaningful when inbox.
    always_comb begin
        col_w = {1'b0, pix.col};
        row_w = {1'b0, pix.row};
        sx    = col_w - X_LO;
        sy    = row_w - Y_LO;
        inbox = pix.visible && (col_w >= X_LO) && (col_w < X_HI)
                            && (row_w >= Y_LO) && (row_w < Y_HI);

        seg_hit    = 7'b0;
        seg_hit[0] = (sy < T_L);                                  // a
        seg_hit[1] = (sx >= R_LO) && (sy < MID_L);                // b
        seg_hit[2] = (sx >= R_LO) && (sy >= MID_L);               // c
        seg_hit[3] = (sy >= D_LO);                                // d
        seg_hit[4] = (sx < T_L) && (sy >= MID_L);                 // e
        seg_hit[5] = (sx < T_L) && (sy < MID_L);                  // f
        seg_hit[6] = (sy >= G_LO) && (sy < G_HI);                 // g

        case (pix.digit)
            4'd0:    seg_lit = 7'b0111111;
            4'd1:    seg_lit = 7'b0000110;
            4'd2:    seg_lit = 7'b1011011;
            4'd3:    seg_lit = 7'b1001111;
            4'd4:    seg_lit = 7'b1100110;
            4'd5:    seg_lit = 7'b1101101;
            4'd6:    seg_lit = 7'b1111101;
            4'd7:    seg_lit = 7'b0000111;
            4'd8:    seg_lit = 7'b1111111;
            4'd9:    seg_lit = 7'b1101111;
            default: seg_lit = 7'b0000000;   // 10-15 draw an empty box
        endcase

        fg = |(seg_hit & seg_lit);
    end

    // Next-state colour selection; border (when built in) overrides segments.
    always_comb begin
        number_on_d  = inbox;
        number_rgb_d = 6'b0;
        if (inbox) begin
            number_rgb_d = fg ? FG_RGB : BG_RGB;
`ifdef NUMBER_GEN_BOX_EN
            if ((sx == 11'd0) || (sx == X_LAST) || (sy == 11'd0) || (sy == Y_LAST))
                number_rgb_d = BOX_RGB;
`endif
        end
    end

    // Output registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_on_q  <= 1'b0;
            number_rgb_q <= 6'b0;
        end else begin
            number_on_q  <= number_on_d;
            number_rgb_q <= number_rgb_d;
        end
    end

    assign pix.number_on  = number_on_q;
    assign pix.number_rgb = number_rgb_q;

endmodule

// File: tb/tb_number_gen.sv
// Directed bench for number_gen at X0=100, Y0=140, W=20, H=30, SEG_T=4.
// Each pixel is driven after a falling edge and checked 1 ns after the next rising edge.
module tb_number_gen;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    number_gen_if pix ();

    number_gen #(
        .X0(100), .Y0(140), .W(20), .H(30), .SEG_T(4),
        .FG_RGB(6'b111111), .BG_RGB(6'b000000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix   (pix.slave)
    );

    localparam logic [5:0] FG = 6'b111111;
    localparam logic [5:0] BG = 6'b000000;
`ifdef NUMBER_GEN_BOX_EN
    localparam logic [5:0] EDGE_BG = 6'b010101;   // border pixel where no segment is lit
    localparam logic [5:0] EDGE_FG = 6'b010101;   // border pixel over a lit segment
`else
    localparam logic [5:0] EDGE_BG = BG;
    localparam logic [5:0] EDGE_FG = FG;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int c, input int r, input int d);
        @(negedge clk);
        pix.visible = v;
        pix.col     = 10'(c);
        pix.row     = 10'(r);
        pix.digit   = 4'(d);
    endtask

    task automatic pixel(input string tag, input logic v, input int c, input int r,
                         input int d, input logic exp_on, input logic [5:0] exp_rgb);
        drive(v, c, r, d);
        @(posedge clk);
        #1;
        check({tag, "_on"},  {5'b0, pix.number_on}, {5'b0, exp_on});
        check({tag, "_rgb"}, pix.number_rgb, exp_rgb);
    endtask

    initial begin
        rst_n = 1'b0;
        pix.visible = 1'b0;
        pix.col = '0;
        pix.row = '0;
        pix.digit = '0;

        // Held in reset with a lit pixel presented: outputs stay zero.
        drive(1'b1, 110, 150, 8);
        @(posedge clk);
        #1;
        check("rst_on",  {5'b0, pix.number_on}, 6'b0);
        check("rst_rgb", pix.number_rgb, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Digit 1
        pixel("d1_a_off", 1'b1, 100, 140, 1, 1'b1, EDGE_BG);
        pixel("d1_b",     1'b1, 118, 145, 1, 1'b1, FG);
        pixel("d1_c",     1'b1, 118, 165, 1, 1'b1, FG);

        // Middle bar, digit changes pixel to pixel
        pixel("g_d8", 1'b1, 110, 154, 8, 1'b1, FG);
        pixel("g_d0", 1'b1, 110, 154, 0, 1'b1, BG);
        pixel("g_d7", 1'b1, 110, 154, 7, 1'b1, BG);
        pixel("g_d3", 1'b1, 110, 156, 3, 1'b1, FG);
        pixel("g_below", 1'b1, 110, 157, 8, 1'b1, BG);

        // Box edges
        pixel("corner_in", 1'b1, 119, 169, 8, 1'b1, EDGE_FG);
        pixel("col_out",   1'b1, 120, 169, 8, 1'b0, 6'b0);
        pixel("left_out",  1'b1,  99, 150, 8, 1'b0, 6'b0);
        pixel("row_out",   1'b1, 110, 170, 8, 1'b0, 6'b0);
        pixel("top_out",   1'b1, 110, 139, 8, 1'b0, 6'b0);

        // Gating and illegal digits
        pixel("invis",   1'b0, 110, 140, 8,  1'b1 & 1'b0, 6'b0);
        pixel("dig12",   1'b1, 110, 140, 12, 1'b1, EDGE_BG);
        pixel("d2_e",    1'b1, 101, 160, 2,  1'b1, FG);
        pixel("d5_e_off",1'b1, 101, 160, 5,  1'b1, BG);

        // Border option (falls back to plain segment colour when not built)
        pixel("box_left", 1'b1, 100, 150, 0, 1'b1, EDGE_FG);
        pixel("box_f",    1'b1, 102, 150, 0, 1'b1, FG);

        // Asynchronous reset mid-stream: outputs drop before the next clock edge.
        pixel("pre_rst", 1'b1, 110, 154, 8, 1'b1, FG);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_on",  {5'b0, pix.number_on}, 6'b0);
        check("arst_rgb", pix.number_rgb, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pixel("post_rst", 1'b1, 118, 145, 4, 1'b1, FG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
